// File: rtl/acq_power_peak_engine_pkg.sv
// Shared acquisition constants and helpers for the I^2+Q^2 power/peak engine.
package acq_power_peak_engine_pkg;
    localparam int ACQ_ACC_WIDTH        = 16;
    localparam int ACQ_NUM_ACCUMULATORS = 3;
    localparam int ACQ_CS_WIDTH         = 11;
    localparam int ACQ_MULT_LATENCY     = 3;
    localparam int ACQ_NONCOH           = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2
    } acq_state_e;

    // Headroom for I^2+Q^2 plus log2(NONCOH) bits of non-coherent growth
    function automatic int acq_pwr_width(input int acc_w, input int noncoh);
        return 2 * acc_w + 1 + $clog2(noncoh);
    endfunction

    function automatic int acq_sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/acq_abs_square.sv
// |x| followed by a LATENCY-deep unsigned squarer; tag and valid ride alongside.
module acq_abs_square #(
    parameter int WIDTH     = 16,
    parameter int LATENCY   = 3,
    parameter int TAG_WIDTH = 3
)(
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_flush,
    input  logic                   i_vld,
    input  logic [WIDTH-1:0]       i_x,
    input  logic [TAG_WIDTH-1:0]   i_tag,
    output logic                   o_vld,
    output logic [2*WIDTH-1:0]     o_sq,
    output logic [TAG_WIDTH-1:0]   o_tag,
    output logic                   o_busy
);
    logic [WIDTH-1:0]                    w_abs;
    logic [2*WIDTH-1:0]                  w_sq;
    logic [LATENCY:1]                    r_vld_pipe;
    logic [LATENCY:1][2*WIDTH-1:0]       r_sq_pipe;
    logic [LATENCY:1][TAG_WIDTH-1:0]     r_tag_pipe;

    // Most-negative input wraps to 2^(WIDTH-1), which is exact as unsigned
    assign w_abs = i_x[WIDTH-1] ? (~i_x + WIDTH'(1)) : i_x;
    assign w_sq  = {{WIDTH{1'b0}}, w_abs} * {{WIDTH{1'b0}}, w_abs};

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vld_pipe <= '0;
            r_sq_pipe  <= '0;
            r_tag_pipe <= '0;
        end else begin
            r_vld_pipe[1] <= i_vld && !i_flush;
            r_sq_pipe[1]  <= w_sq;
            r_tag_pipe[1] <= i_tag;
            for (int s = 2; s <= LATENCY; s++) begin
                r_vld_pipe[s] <= r_vld_pipe[s-1] && !i_flush;
                r_sq_pipe[s]  <= r_sq_pipe[s-1];
                r_tag_pipe[s] <= r_tag_pipe[s-1];
            end
        end
    end

    assign o_vld  = r_vld_pipe[LATENCY];
    assign o_sq   = r_sq_pipe[LATENCY];
    assign o_tag  = r_tag_pipe[LATENCY];
    assign o_busy = |r_vld_pipe;
endmodule

// File: rtl/acq_power_peak_engine.sv
// Per-bin I^2+Q^2 through one shared squarer, optional non-coherent sum, running peak.
module acq_power_peak_engine
    import acq_power_peak_engine_pkg::*;
#(
    parameter int  NUM_ACC      = ACQ_NUM_ACCUMULATORS,
    parameter int  ACC_WIDTH    = ACQ_ACC_WIDTH,
    parameter int  CS_WIDTH     = ACQ_CS_WIDTH,
    parameter int  NONCOH       = ACQ_NONCOH,
    parameter int  MULT_LATENCY = ACQ_MULT_LATENCY,
    localparam int SEL_WIDTH    = acq_sel_width(NUM_ACC),
    localparam int PWR_WIDTH    = acq_pwr_width(ACC_WIDTH, NONCOH)
)(
    input  logic                         clk,
    input  logic                         global_reset,
    input  logic                         acc_valid,
    input  logic [NUM_ACC*ACC_WIDTH-1:0] acc_i,
    input  logic [NUM_ACC*ACC_WIDTH-1:0] acc_q,
    input  logic [CS_WIDTH-1:0]          code_shift,
    input  logic                         peak_clear,
    output logic                         busy,
    output logic                         pwr_valid,
    output logic [PWR_WIDTH-1:0]         pwr_value,
    output logic [SEL_WIDTH-1:0]         pwr_tag,
    output logic [PWR_WIDTH-1:0]         peak_power,
    output logic [SEL_WIDTH-1:0]         peak_bin,
    output logic [CS_WIDTH-1:0]          peak_code_shift,
    output logic                         overrun
);
    localparam int FRM_WIDTH = (NONCOH > 1) ? $clog2(NONCOH) : 1;
    localparam int SQ_WIDTH  = 2 * ACC_WIDTH;
    localparam int TAG_WIDTH = SEL_WIDTH + 1;

    acq_state_e                          r_state, w_next_state;
    logic [NUM_ACC-1:0][ACC_WIDTH-1:0]   r_snap_i, r_snap_q;
    logic [CS_WIDTH-1:0]                 r_snap_cs;
    logic [SEL_WIDTH-1:0]                r_sel;
    logic                                r_is_q;
    logic [FRM_WIDTH-1:0]                r_frame;
    logic                                w_accept, w_feed, w_last_op, w_last_frame;
    logic [ACC_WIDTH-1:0]                w_operand;
    logic                                w_sq_vld, w_sq_busy, w_sq_is_q;
    logic [SQ_WIDTH-1:0]                 w_sq;
    logic [TAG_WIDTH-1:0]                w_sq_tag;
    logic [SEL_WIDTH-1:0]                w_sq_bin;
    logic [SQ_WIDTH-1:0]                 r_i_sq;
    logic [NUM_ACC-1:0][PWR_WIDTH-1:0]   r_nc_sum;
    logic [SQ_WIDTH:0]                   w_pwr;
    logic [PWR_WIDTH-1:0]                w_acc;
    logic                                r_pwr_valid;
    logic [PWR_WIDTH-1:0]                r_pwr_value, r_peak_power;
    logic [SEL_WIDTH-1:0]                r_pwr_tag, r_peak_bin;
    logic [CS_WIDTH-1:0]                 r_peak_cs;
    logic                                r_overrun;

    assign w_accept     = (r_state == ST_IDLE) && acc_valid && !peak_clear;
    assign w_last_op    = r_is_q && (r_sel == SEL_WIDTH'(NUM_ACC - 1));
    assign w_last_frame = (r_frame == FRM_WIDTH'(NONCOH - 1));

    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) r_state <= ST_IDLE;
        else              r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)   w_next_state = ST_FEED;
            ST_FEED:  if (w_last_op)  w_next_state = ST_DRAIN;
            ST_DRAIN: if (!w_sq_busy) w_next_state = ST_IDLE;
            default:                  w_next_state = ST_IDLE;
        endcase
        if (peak_clear) w_next_state = ST_IDLE;
    end

    always_comb begin
        busy   = (r_state != ST_IDLE);
        w_feed = (r_state == ST_FEED);
    end

    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            r_snap_i  <= '0;
            r_snap_q  <= '0;
            r_snap_cs <= '0;
            r_sel     <= '0;
            r_is_q    <= 1'b0;
        end else if (w_accept) begin
            r_snap_i  <= acc_i;
            r_snap_q  <= acc_q;
            r_snap_cs <= code_shift;
            r_sel     <= '0;
            r_is_q    <= 1'b0;
        end else if (w_feed) begin
            r_is_q <= !r_is_q;
            if (r_is_q) r_sel <= r_sel + SEL_WIDTH'(1);
        end
    end

    assign w_operand = r_is_q ? r_snap_q[r_sel] : r_snap_i[r_sel];

    acq_abs_square #(
        .WIDTH     (ACC_WIDTH),
        .LATENCY   (MULT_LATENCY),
        .TAG_WIDTH (TAG_WIDTH)
    ) u_abs_square (
        .i_clk   (clk),
        .i_rst   (global_reset),
        .i_flush (peak_clear),
        .i_vld   (w_feed),
        .i_x     (w_operand),
        .i_tag   ({r_sel, r_is_q}),
        .o_vld   (w_sq_vld),
        .o_sq    (w_sq),
        .o_tag   (w_sq_tag),
        .o_busy  (w_sq_busy)
    );

    assign {w_sq_bin, w_sq_is_q} = w_sq_tag;
    assign w_pwr = {1'b0, r_i_sq} + {1'b0, w_sq};
    // Frame 0 restarts the sum so stale values from an aborted run never leak in
    assign w_acc = ((r_frame == '0) ? PWR_WIDTH'(0) : r_nc_sum[w_sq_bin]) + PWR_WIDTH'(w_pwr);

    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            r_i_sq      <= '0;
            r_nc_sum    <= '0;
            r_pwr_valid <= 1'b0;
            r_pwr_value <= '0;
            r_pwr_tag   <= '0;
        end else begin
            r_pwr_valid <= 1'b0;
            if (!peak_clear && w_sq_vld) begin
                if (!w_sq_is_q) begin
                    r_i_sq <= w_sq;
                end else begin
                    r_nc_sum[w_sq_bin] <= w_acc;
                    if (w_last_frame) begin
                        r_pwr_valid <= 1'b1;
                        r_pwr_value <= w_acc;
                        r_pwr_tag   <= w_sq_bin;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            r_frame <= '0;
        end else if (peak_clear) begin
            r_frame <= '0;
        end else if (r_state == ST_DRAIN && w_next_state == ST_IDLE) begin
            r_frame <= w_last_frame ? '0 : r_frame + FRM_WIDTH'(1);
        end
    end

    // Strict compare: ties keep the earlier bin / code shift
    always_ff @(posedge clk or posedge global_reset) begin
        if (global_reset) begin
            r_peak_power <= '0;
            r_peak_bin   <= '0;
            r_peak_cs    <= '0;
            r_overrun    <= 1'b0;
        end else if (peak_clear) begin
            r_peak_power <= '0;
            r_peak_bin   <= '0;
            r_peak_cs    <= '0;
            r_overrun    <= 1'b0;
        end else begin
            if (r_pwr_valid && (r_pwr_value > r_peak_power)) begin
                r_peak_power <= r_pwr_value;
                r_peak_bin   <= r_pwr_tag;
                r_peak_cs    <= r_snap_cs;
            end
            if (acc_valid && busy) r_overrun <= 1'b1;
        end
    end

    assign pwr_valid       = r_pwr_valid;
    assign pwr_value       = r_pwr_value;
    assign pwr_tag         = r_pwr_tag;
    assign peak_power      = r_peak_power;
    assign peak_bin        = r_peak_bin;
    assign peak_code_shift = r_peak_cs;
    assign overrun         = r_overrun;
endmodule

// File: tb/tb_acq_power_peak_engine.sv
// Directed bench: coherent instance (NONCOH=1) and non-coherent instance (NONCOH=4) on shared stimulus.
module tb_acq_power_peak_engine;
    localparam int NA = 3;
    localparam int W  = 16;
    localparam int CW = 11;
    localparam int PW = 33;
    localparam int PN = 35;

    logic            clk = 1'b0;
    logic            global_reset, acc_valid, peak_clear;
    logic [NA*W-1:0] acc_i, acc_q;
    logic [CW-1:0]   code_shift;

    logic            busy, pwr_valid, overrun;
    logic [PW-1:0]   pwr_value, peak_power;
    logic [1:0]      pwr_tag, peak_bin;
    logic [CW-1:0]   peak_code_shift;

    logic            nc_busy, nc_pwr_valid, nc_overrun;
    logic [PN-1:0]   nc_pwr_value, nc_peak_power;
    logic [1:0]      nc_pwr_tag, nc_peak_bin;
    logic [CW-1:0]   nc_peak_cs;

    int n_checks = 0;
    int n_fail   = 0;

    int            ev_cyc[$];
    logic [PW-1:0] ev_val[$];
    logic [1:0]    ev_tag[$];
    logic [PN-1:0] nc_val[$];
    logic [1:0]    nc_tag[$];
    int            idle_c;

    always #5 clk = ~clk;

    acq_power_peak_engine dut (
        .clk(clk), .global_reset(global_reset), .acc_valid(acc_valid),
        .acc_i(acc_i), .acc_q(acc_q), .code_shift(code_shift), .peak_clear(peak_clear),
        .busy(busy), .pwr_valid(pwr_valid), .pwr_value(pwr_value), .pwr_tag(pwr_tag),
        .peak_power(peak_power), .peak_bin(peak_bin), .peak_code_shift(peak_code_shift),
        .overrun(overrun)
    );

    acq_power_peak_engine #(.NONCOH(4)) dut_nc (
        .clk(clk), .global_reset(global_reset), .acc_valid(acc_valid),
        .acc_i(acc_i), .acc_q(acc_q), .code_shift(code_shift), .peak_clear(peak_clear),
        .busy(nc_busy), .pwr_valid(nc_pwr_valid), .pwr_value(nc_pwr_value), .pwr_tag(nc_pwr_tag),
        .peak_power(nc_peak_power), .peak_bin(nc_peak_bin), .peak_code_shift(nc_peak_cs),
        .overrun(nc_overrun)
    );

    function automatic logic [NA*W-1:0] pack3(input int a, input int b, input int c);
        logic [W-1:0] x, y, z;
        x = a[W-1:0];
        y = b[W-1:0];
        z = c[W-1:0];
        return {z, y, x};
    endfunction

    // Drives acc_valid in cycle 0; collect() then runs from cycle 1
    task automatic send(input logic [NA*W-1:0] i, input logic [NA*W-1:0] q, input int cs);
        @(negedge clk);
        acc_i      = i;
        acc_q      = q;
        code_shift = cs[CW-1:0];
        acc_valid  = 1'b1;
    endtask

    task automatic collect(input int ncyc, input int pulse_c, input int clear_c, input int rst_c);
        ev_cyc.delete(); ev_val.delete(); ev_tag.delete();
        nc_val.delete(); nc_tag.delete();
        idle_c = -1;
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge clk);
            acc_valid    = (c == pulse_c);
            peak_clear   = (c == clear_c);
            global_reset = (c == rst_c);
            #1;
            if (pwr_valid) begin
                ev_cyc.push_back(c);
                ev_val.push_back(pwr_value);
                ev_tag.push_back(pwr_tag);
            end
            if (nc_pwr_valid) begin
                nc_val.push_back(nc_pwr_value);
                nc_tag.push_back(nc_pwr_tag);
            end
            if (!busy && idle_c < 0) idle_c = c;
        end
        @(negedge clk);
        acc_valid = 1'b0; peak_clear = 1'b0; global_reset = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        peak_clear = 1'b1;
        @(negedge clk);
        peak_clear = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        global_reset = 1'b1; acc_valid = 1'b0; peak_clear = 1'b0;
        acc_i = '0; acc_q = '0; code_shift = '0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({busy, pwr_valid, pwr_value, pwr_tag, overrun} !== '0) begin
            n_fail++; $display("FAIL reset_out: got busy=%b vld=%b val=%0d tag=%0d ovr=%b want all 0",
                               busy, pwr_valid, pwr_value, pwr_tag, overrun);
        end
        n_checks++;
        if ({peak_power, peak_bin, peak_code_shift} !== '0) begin
            n_fail++; $display("FAIL reset_peak: got %0d/%0d/%0d want 0/0/0", peak_power, peak_bin, peak_code_shift);
        end
        global_reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    endtask

    task automatic test_basic();
        send(pack3(3, -4, 0), pack3(4, 3, -5), 100);
        collect(14, -1, -1, -1);
        n_checks++;
        if (ev_cyc.size() != 3) begin n_fail++; $display("FAIL basic_count: got %0d want 3", ev_cyc.size()); end
        for (int k = 0; k < 3 && k < ev_cyc.size(); k++) begin
            n_checks++;
            if (ev_cyc[k] != 6 + 2*k) begin n_fail++; $display("FAIL basic_cyc%0d: got %0d want %0d", k, ev_cyc[k], 6+2*k); end
            n_checks++;
            if (ev_val[k] !== PW'(25)) begin n_fail++; $display("FAIL basic_val%0d: got %0d want 25", k, ev_val[k]); end
            n_checks++;
            if (ev_tag[k] !== 2'(k)) begin n_fail++; $display("FAIL basic_tag%0d: got %0d want %0d", k, ev_tag[k], k); end
        end
        n_checks++;
        if (idle_c != 11) begin n_fail++; $display("FAIL basic_busy_fall: got %0d want 11", idle_c); end
        n_checks++;
        if ({peak_power, peak_bin, peak_code_shift} !== {PW'(25), 2'd0, CW'(100)}) begin
            n_fail++; $display("FAIL basic_peak: got %0d/%0d/%0d want 25/0/100", peak_power, peak_bin, peak_code_shift);
        end
    endtask

    task automatic test_peak_update();
        send(pack3(0, 10, 0), pack3(0, 0, 1), 200);
        collect(14, -1, -1, -1);
        n_checks++;
        if (ev_val.size() != 3 || ev_val[1] !== PW'(100) || ev_val[2] !== PW'(1)) begin
            n_fail++; $display("FAIL upd_vals: got n=%0d want 0,100,1", ev_val.size());
        end
        n_checks++;
        if ({peak_power, peak_bin, peak_code_shift} !== {PW'(100), 2'd1, CW'(200)}) begin
            n_fail++; $display("FAIL upd_peak: got %0d/%0d/%0d want 100/1/200", peak_power, peak_bin, peak_code_shift);
        end
        send(pack3(6, 0, -10), pack3(8, 0, 0), 300);
        collect(14, -1, -1, -1);
        n_checks++;
        if (ev_val.size() != 3 || ev_val[0] !== PW'(100) || ev_val[2] !== PW'(100)) begin
            n_fail++; $display("FAIL tie_vals: got n=%0d want 100,0,100", ev_val.size());
        end
        n_checks++;
        if ({peak_power, peak_bin, peak_code_shift} !== {PW'(100), 2'd1, CW'(200)}) begin
            n_fail++; $display("FAIL tie_peak: got %0d/%0d/%0d want 100/1/200", peak_power, peak_bin, peak_code_shift);
        end
    endtask

    task automatic test_extreme();
        send(pack3(-32768, 0, 0), pack3(-32768, 0, 0), 400);
        collect(14, -1, -1, -1);
        n_checks++;
        if (ev_val.size() < 1 || ev_val[0] !== 33'h0_8000_0000) begin
            n_fail++; $display("FAIL extreme_val: got %h want 080000000", (ev_val.size() > 0) ? ev_val[0] : '0);
        end
        n_checks++;
        if ({peak_power, peak_bin, peak_code_shift} !== {33'h0_8000_0000, 2'd0, CW'(400)}) begin
            n_fail++; $display("FAIL extreme_peak: got %h/%0d/%0d want 080000000/0/400", peak_power, peak_bin, peak_code_shift);
        end
    endtask

    task automatic test_overrun();
        n_checks++;
        if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pre: got %b want 0", overrun); end
        send(pack3(1, 1, 1), pack3(1, 1, 1), 500);
        collect(14, 2, -1, -1);
        n_checks++;
        if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun); end
        n_checks++;
        if (ev_val.size() != 3 || idle_c != 11) begin
            n_fail++; $display("FAIL ovr_ignored: got events=%0d idle=%0d want 3/11", ev_val.size(), idle_c);
        end
        do_clear();
        n_checks++;
        if ({overrun, peak_power, peak_bin, peak_code_shift} !== '0) begin
            n_fail++; $display("FAIL ovr_clear: got ovr=%b peak=%0d/%0d/%0d want 0", overrun, peak_power, peak_bin, peak_code_shift);
        end
    endtask

    task automatic test_noncoh();
        int exp_n;
        do_clear();
        for (int k = 0; k < 8; k++) begin
            send(pack3(1, 0, 0), pack3(2, 0, 0), 10 + k);
            collect(14, -1, -1, -1);
            exp_n = ((k % 4) == 3) ? 3 : 0;
            n_checks++;
            if (nc_val.size() != exp_n) begin
                n_fail++; $display("FAIL nc_count%0d: got %0d want %0d", k, nc_val.size(), exp_n);
            end else if (exp_n == 3) begin
                n_checks++;
                if (nc_val[0] !== PN'(20) || nc_tag[0] !== 2'd0 || nc_val[1] !== PN'(0)) begin
                    n_fail++; $display("FAIL nc_val%0d: got %0d tag %0d want 20 tag 0", k, nc_val[0], nc_tag[0]);
                end
                n_checks++;
                if ({nc_peak_power, nc_peak_bin, nc_peak_cs} !== {PN'(20), 2'd0, CW'(13)}) begin
                    n_fail++; $display("FAIL nc_peak%0d: got %0d/%0d/%0d want 20/0/13", k, nc_peak_power, nc_peak_bin, nc_peak_cs);
                end
            end
        end
        n_checks++;
        if (ev_val.size() != 3 || ev_val[0] !== PW'(5)) begin
            n_fail++; $display("FAIL coh_frame: got n=%0d want 3 events, first 5", ev_val.size());
        end
    endtask

    task automatic test_abort_clear();
        send(pack3(3, -4, 0), pack3(4, 3, -5), 600);
        collect(14, -1, 4, -1);
        n_checks++;
        if (ev_val.size() != 0 || nc_val.size() != 0) begin
            n_fail++; $display("FAIL clr_abort: got events=%0d/%0d want 0/0", ev_val.size(), nc_val.size());
        end
        n_checks++;
        if (idle_c != 5) begin n_fail++; $display("FAIL clr_busy: got idle at %0d want 5", idle_c); end
        n_checks++;
        if (peak_power !== '0) begin n_fail++; $display("FAIL clr_peak: got %0d want 0", peak_power); end
    endtask

    task automatic test_abort_reset();
        send(pack3(3, -4, 0), pack3(4, 3, -5), 700);
        collect(14, -1, -1, -1);
        n_checks++;
        if (peak_power !== PW'(25)) begin n_fail++; $display("FAIL rst_pre_peak: got %0d want 25", peak_power); end
        send(pack3(3, -4, 0), pack3(4, 3, -5), 701);
        collect(14, 2, -1, 3);
        n_checks++;
        if (ev_val.size() != 0 || idle_c != 3) begin
            n_fail++; $display("FAIL rst_abort: got events=%0d idle=%0d want 0/3", ev_val.size(), idle_c);
        end
        n_checks++;
        if ({busy, pwr_valid, pwr_value, pwr_tag, peak_power, peak_bin, peak_code_shift, overrun} !== '0) begin
            n_fail++; $display("FAIL rst_outputs: got val=%0d tag=%0d peak=%0d/%0d/%0d ovr=%b want 0",
                               pwr_value, pwr_tag, peak_power, peak_bin, peak_code_shift, overrun);
        end
        send(pack3(3, -4, 0), pack3(4, 3, -5), 702);
        collect(14, -1, -1, -1);
        n_checks++;
        if (ev_val.size() != 3 || peak_code_shift !== CW'(702)) begin
            n_fail++; $display("FAIL rst_recover: got events=%0d cs=%0d want 3/702", ev_val.size(), peak_code_shift);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_peak_update();
        test_extreme();
        test_overrun();
        test_noncoh();
        test_abort_clear();
        test_abort_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
